seq_reduce_unit: RTL and testbench
==================================

Name: seq_reduce_unit

Overview:
- Parametrised, multi-cycle successor to the team's fixed 8-input gate-level OR.
- Reduces a WIDTH-bit word to one bit using a selectable function: OR, AND, XOR or NOR.
- Processes CHUNK bits per clock, LSB slice first, under a start/done handshake.
- Serves as the generic reduction engine for wide flag and parity checks in lab datapaths.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK and >= CHUNK.
- CHUNK, 8, bits reduced per cycle; N = WIDTH/CHUNK is the number of slices.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while idle
- mode  input  2  00 OR, 01 AND, 10 XOR, 11 NOR; captured with start
- data_in  input  WIDTH  operand; captured with start
- busy  output  1  high while a reduction is in progress
- done  output  1  one-cycle pulse when result is updated
- result  output  1  reduced bit; holds until the next done

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, accumulator=0, slice counter=0, captured mode/data=0.
- States: IDLE, RUN.
- IDLE with start=1 at edge T0:
  - capture data_in and mode;
  - acc = identity: 0 for OR/XOR/NOR, 1 for AND;
  - cnt = 0; go to RUN; busy=1 after T0.
- RUN, edge Tk (k=1..N):
  - reduce slice [k*CHUNK-1 : (k-1)*CHUNK] to one bit with the base function (OR for NOR);
  - combine that bit into acc with the same function; cnt increments.
- Edge TN (last slice):
  - result = final acc, inverted when mode=11;
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done high N cycles after start is sampled (4 for the defaults); result valid in the same cycle as done.
- Throughput: one operation per N+1 cycles. A start in the cycle done is high is accepted (the block is already IDLE), giving back-to-back operation at N+1 cycles.
- start while busy: ignored, no effect on captured data or mode.
- data_in/mode changes during RUN: no effect.
- rst mid-operation: immediate abort to reset values; no done pulse.
- N=1 (WIDTH==CHUNK): done one cycle after start.
- done never asserts without a prior accepted start.

Optional Feature:
- Macro: REDUCE_CHAIN_EN.
- Defined:
  - adds input port chain (1 bit), sampled with start;
  - when chain=1, acc initialises to the current result instead of the identity (for NOR, the un-inverted previous acc);
  - cascades words longer than WIDTH across successive operations;
  - chain is ignored when mode differs from the previous operation's mode, and also after reset.
- Undefined: no chain port; acc always starts at the identity.

Test Plan:
- Reset, then mode=00 with data_in=32'h0000_0000 -> done at T4, result=0; repeat with 32'h0000_0100 -> result=1.
- mode=01: 32'hFFFF_FFFF -> result=1; 32'hFFFF_FFFE -> result=0. busy high exactly 4 cycles, done high 1 cycle.
- mode=10 with 32'h0000_0007 -> result=1; mode=11 with 32'h0 -> result=1; mode=11 with 32'h8000_0000 -> result=0.
- Start with 32'h1 (OR), then pulse start with 32'h0/AND at T2 -> ignored, result=1 at T4. Start again in the done cycle -> accepted, next done 4 cycles later.
- Assert rst at T2 of a run -> busy=0, result=0, no done. Next start with 32'hF0 (OR) -> result=1 at T4.
- REDUCE_CHAIN_EN, XOR mode:
  - 32'h1, chain=0 -> result=1;
  - then 32'h1, chain=1 -> result=0;
  - then AND mode with chain=1 -> chain ignored, identity used.

Source files
------------

// File: rtl/seq_reduce_unit.sv
// seq_reduce_unit
//   Multi-cycle reduction of a WIDTH-bit word to a single bit. The word is
//   consumed CHUNK bits per clock, least-significant slice first, so that
//   N = WIDTH/CHUNK clocks after an accepted start the result is published
//   together with a one-cycle done pulse.
//
//   Reduction functions (mode):
//     2'b00 OR    2'b01 AND    2'b10 XOR    2'b11 NOR (OR, inverted at the end)
//
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous, active-high reset
//     start    in   request; sampled only while idle
//     mode     in   [1:0] reduction function; captured with start
//     data_in  in   [WIDTH-1:0] operand; captured with start
//     chain    in   (REDUCE_CHAIN_EN only) seed acc with the previous result
//     busy     out  high while a reduction is in progress
//     done     out  one-cycle pulse when result is updated
//     result   out  reduced bit; holds until the next done
//
//   Build option:
//     REDUCE_CHAIN_EN  when defined, adds the chain input so that words wider
//                      than WIDTH can be reduced across successive operations.
//                      Chaining only applies when the mode matches the previous
//                      completed operation and never right after reset.

module seq_reduce_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
`ifdef REDUCE_CHAIN_EN
  input  logic             chain,
`endif
  output logic             busy,
  output logic             done,
  output logic             result
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_param_check
    $error("seq_reduce_unit: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             acc_q,    acc_d;
  mode_e            mode_q,   mode_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             result_q, result_d;
  logic             done_q,   done_d;

`ifdef REDUCE_CHAIN_EN
  // Un-inverted accumulator and mode of the last completed operation; the
  // valid flag keeps a chain request from using stale state after reset.
  logic             last_acc_q,  last_acc_d;
  mode_e            last_mode_q, last_mode_d;
  logic             last_vld_q,  last_vld_d;
`endif

  // Current slice and its one-bit reduction with the base function.
  logic [WIDTH-1:0] shifted;
  logic [CHUNK-1:0] slice;
  logic             slice_bit;
  logic             acc_step;
  logic             acc_init;

  always_comb begin
    shifted = data_q >> (32'(cnt_q) * CHUNK);
    slice   = shifted[CHUNK-1:0];
    unique case (mode_q)
      MODE_AND: slice_bit = &slice;
      MODE_XOR: slice_bit = ^slice;
      default:  slice_bit = |slice;
    endcase
    unique case (mode_q)
      MODE_AND: acc_step = acc_q & slice_bit;
      MODE_XOR: acc_step = acc_q ^ slice_bit;
      default:  acc_step = acc_q | slice_bit;
    endcase
  end

  // Starting accumulator for a newly accepted operation.
  always_comb begin
    acc_init = (mode_e'(mode) == MODE_AND);
`ifdef REDUCE_CHAIN_EN
    if (chain && last_vld_q && (mode_e'(mode) == last_mode_q)) begin
      acc_init = last_acc_q;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    data_d   = data_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef REDUCE_CHAIN_EN
    last_acc_d  = last_acc_q;
    last_mode_d = last_mode_q;
    last_vld_d  = last_vld_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          mode_d  = mode_e'(mode);
          acc_d   = acc_init;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d = acc_step;
        if (cnt_q == LAST) begin
          result_d = (mode_q == MODE_NOR) ? ~acc_step : acc_step;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
`ifdef REDUCE_CHAIN_EN
          last_acc_d  = acc_step;
          last_mode_d = mode_q;
          last_vld_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      mode_q   <= MODE_OR;
      data_q   <= '0;
      result_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

`ifdef REDUCE_CHAIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_acc_q  <= 1'b0;
      last_mode_q <= MODE_OR;
      last_vld_q  <= 1'b0;
    end else begin
      last_acc_q  <= last_acc_d;
      last_mode_q <= last_mode_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_reduce_unit.sv
// Testbench for seq_reduce_unit: directed scenarios followed by randomized
// start/idle/reset traffic. The driver predicts each accepted operation from
// whole-word arithmetic and queues the expected result and timing; a monitor
// on the falling edge compares busy, done and result every cycle.

module tb_seq_reduce_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             chain;
  logic             busy;
  logic             done;
  logic             result;

  seq_reduce_unit #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .data_in (data_in),
`ifdef REDUCE_CHAIN_EN
    .chain   (chain),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned acc_edge;
    int unsigned done_edge;
    logic        res;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        model_result = 1'b0;
  int unsigned free_edge = 0;
  logic        prev_vld = 1'b0;
  logic [1:0]  prev_mode = 2'b00;
  logic        prev_acc = 1'b0;

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  // Monitor: expected outputs come only from the scoreboard and the model.
  always @(negedge clk) begin
    logic exp_done;
    logic exp_busy;
    exp_done = (sb.size() > 0) && (sb[0].done_edge == cyc);
    exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc_edge) && (cyc < sb[0].done_edge);
    if (exp_done) model_result = sb[0].res;
    chk("done", done, exp_done);
    chk("busy", busy, exp_busy);
    chk("result", result, model_result);
    if (exp_done) void'(sb.pop_front());
  end

  // Whole-word reference: returns the un-inverted accumulator.
  function automatic logic ref_acc(input logic [1:0] m, input logic [WIDTH-1:0] d,
                                   input logic init);
    case (m)
      2'b01:   return init & (d == {WIDTH{1'b1}});
      2'b10:   return init ^ ($countones(d) % 2 == 1);
      default: return init | (d != '0);
    endcase
  endfunction

  task automatic issue(input logic [1:0] m, input logic [WIDTH-1:0] d, input logic ch);
    logic init;
    logic acc;
    @(negedge clk);
    #1;
    start   = 1'b1;
    mode    = m;
    data_in = d;
    chain   = ch;
    if (cyc + 1 >= free_edge) begin
      init = (m == 2'b01);
`ifdef REDUCE_CHAIN_EN
      if (ch && prev_vld && (m == prev_mode)) init = prev_acc;
`endif
      acc = ref_acc(m, d, init);
      sb.push_back('{acc_edge: cyc + 1, done_edge: cyc + 1 + N,
                     res: (m == 2'b11) ? ~acc : acc});
      free_edge = cyc + 2 + N;
      prev_vld  = 1'b1;
      prev_mode = m;
      prev_acc  = acc;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode    = 2'($urandom);
    data_in = $urandom;
    chain   = 1'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    sb.delete();
    free_edge    = 0;
    prev_vld     = 1'b0;
    model_result = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] one;
    one = 1;
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return one << $urandom_range(0, WIDTH - 1);
      3:       return ~(one << $urandom_range(0, WIDTH - 1));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    data_in = '0;
    chain   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    issue(2'b00, 32'h0000_0000, 1'b0); idle(N + 1);
    issue(2'b00, 32'h0000_0100, 1'b0); idle(N + 1);
    issue(2'b01, 32'hFFFF_FFFF, 1'b0); idle(N + 1);
    issue(2'b01, 32'hFFFF_FFFE, 1'b0); idle(N + 1);
    issue(2'b10, 32'h0000_0007, 1'b0); idle(N + 1);
    issue(2'b11, 32'h0000_0000, 1'b0); idle(N + 1);
    issue(2'b11, 32'h8000_0000, 1'b0); idle(N + 1);

    // Start while busy is ignored; a start in the done cycle is accepted.
    issue(2'b00, 32'h0000_0001, 1'b0); idle(1);
    issue(2'b01, 32'h0000_0000, 1'b0); idle(N - 2);
    issue(2'b01, 32'hFFFF_FFFF, 1'b0); idle(N + 2);

    // Reset in the middle of a run, then a fresh operation.
    issue(2'b00, 32'h0000_00FF, 1'b0); idle(2);
    do_reset(1);
    issue(2'b00, 32'h0000_00F0, 1'b0); idle(N + 2);

`ifdef REDUCE_CHAIN_EN
    issue(2'b10, 32'h0000_0001, 1'b0); idle(N + 1);
    issue(2'b10, 32'h0000_0001, 1'b1); idle(N + 1);
    issue(2'b01, 32'hFFFF_FFFF, 1'b1); idle(N + 1);
    issue(2'b00, 32'h0000_0010, 1'b0); idle(N + 1);
    do_reset(1);
    issue(2'b00, 32'h0000_0000, 1'b1); idle(N + 1);
`endif

    repeat (500) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset($urandom_range(1, 2));
      end else if (r < 65) begin
        issue(2'($urandom), rand_word(), 1'($urandom));
      end else begin
        idle($urandom_range(1, 3));
      end
    end

    idle(N + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
